// File: rtl/wait_pkg.sv
// rtl/wait_pkg.sv - states, command codes and command-name decoding for wait_event_monitor
package wait_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_WAIT,
        S_DONE
    } state_e;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_RISE,
        CMD_FALL,
        CMD_HIGH,
        CMD_LOW,
        CMD_DURATION
    } cmd_e;

    localparam string CMD_NAME_RISE     = "WAIT_RISE";
    localparam string CMD_NAME_FALL     = "WAIT_FALL";
    localparam string CMD_NAME_HIGH     = "WAIT_HIGH";
    localparam string CMD_NAME_LOW      = "WAIT_LOW";
    localparam string CMD_NAME_DURATION = "WAIT_DURATION";

    // CMD_NONE doubles as the "unknown command" code.
    function automatic cmd_e str_to_cmd(input string s);
        cmd_e c;
        c = CMD_NONE;
        if (s == CMD_NAME_RISE)          c = CMD_RISE;
        else if (s == CMD_NAME_FALL)     c = CMD_FALL;
        else if (s == CMD_NAME_HIGH)     c = CMD_HIGH;
        else if (s == CMD_NAME_LOW)      c = CMD_LOW;
        else if (s == CMD_NAME_DURATION) c = CMD_DURATION;
        return c;
    endfunction

endpackage

// File: rtl/wait_event_monitor_if.sv
// rtl/wait_event_monitor_if.sv - decoder-side command bus and response pulses of the wait monitor
interface wait_event_monitor_if #(
    parameter int ARGS_NB = 5
);
    logic  i_sel_wait;
    logic  i_args_valid;
    string i_args [ARGS_NB];
    logic  o_ack;
    logic  o_timeout;
    logic  o_error;
    logic  o_busy;

    modport master (
        output i_sel_wait, i_args_valid, i_args,
        input  o_ack, o_timeout, o_error, o_busy
    );

    modport slave (
        input  i_sel_wait, i_args_valid, i_args,
        output o_ack, o_timeout, o_error, o_busy
    );
endinterface

// File: rtl/edge_detector.sv
// rtl/edge_detector.sv - free-running one-bit edge detector against a registered copy
module edge_detector (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall,
    output logic level
);
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b0;
        else        prev <= d;
    end

    assign rise  = d & ~prev;
    assign fall  = ~d & prev;
    assign level = d;
endmodule

// File: rtl/wait_event_monitor.sv
// rtl/wait_event_monitor.sv - wait-command executor; WAIT_EVENT_MONITOR_LOG_EN enables event messages
module wait_event_monitor
    import wait_pkg::*;
#(
    parameter int WAIT_SIZE     = 5,
    parameter int ARGS_NB       = 5,
    parameter int TIMEOUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  string                i_wait_alias [WAIT_SIZE],
    input  logic [WAIT_SIZE-1:0] i_wait,
    wait_event_monitor_if.slave  bus
);
    localparam int CHW = (WAIT_SIZE > 1) ? $clog2(WAIT_SIZE) : 1;
    localparam int TW  = TIMEOUT_WIDTH;

    state_e         state;
    cmd_e           cmd_q, dec_cmd;
    logic [CHW-1:0] chan_q, alias_idx;
    logic           alias_hit;
    logic [TW-1:0]  count_q, limit_q, arg_count;
    string          cmd_str, alias_str, count_str;
    logic           capture, expire, evt_hit, tmo_hit;
    logic           ack_q, timeout_q, error_q, busy_q;

    logic [WAIT_SIZE-1:0] rise, fall, level;

    for (genvar g = 0; g < WAIT_SIZE; g++) begin : g_edge
        edge_detector u_edge (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (i_wait[g]),
            .rise  (rise[g]),
            .fall  (fall[g]),
            .level (level[g])
        );
    end

    assign capture = bus.i_args_valid & bus.i_sel_wait;

    always_comb begin
        count_str = bus.i_args[2];
        arg_count = TW'(count_str.atoi());
    end

    // Walk downwards so the lowest matching index is the one that sticks.
    always_comb begin
        dec_cmd   = str_to_cmd(cmd_str);
        alias_hit = 1'b0;
        alias_idx = '0;
        for (int k = WAIT_SIZE - 1; k >= 0; k--) begin
            if (i_wait_alias[k] == alias_str) begin
                alias_hit = 1'b1;
                alias_idx = CHW'(k);
            end
        end
    end

    assign expire = (limit_q != '0) && (count_q == limit_q - TW'(1));

    always_comb begin
        evt_hit = 1'b0;
        case (cmd_q)
            CMD_RISE:     evt_hit = rise[chan_q];
            CMD_FALL:     evt_hit = fall[chan_q];
            CMD_HIGH:     evt_hit = level[chan_q];
            CMD_LOW:      evt_hit = ~level[chan_q];
            CMD_DURATION: evt_hit = expire;
            default:      evt_hit = 1'b0;
        endcase
    end

    assign tmo_hit = expire && (cmd_q != CMD_DURATION);

    always_ff @(posedge clk) begin
        if (state == S_IDLE && capture) begin
            cmd_str   <= bus.i_args[0];
            alias_str <= bus.i_args[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cmd_q     <= CMD_NONE;
            chan_q    <= '0;
            count_q   <= '0;
            limit_q   <= '0;
            ack_q     <= 1'b0;
            timeout_q <= 1'b0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            ack_q     <= 1'b0;
            timeout_q <= 1'b0;
            error_q   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (capture) begin
                        limit_q <= arg_count;
                        busy_q  <= 1'b1;
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    count_q <= '0;
                    cmd_q   <= dec_cmd;
                    chan_q  <= alias_idx;
                    if (dec_cmd == CMD_NONE || (dec_cmd != CMD_DURATION && !alias_hit)) begin
                        ack_q   <= 1'b1;
                        error_q <= 1'b1;
                        state   <= S_DONE;
                    end else if (dec_cmd == CMD_DURATION && limit_q == '0) begin
                        ack_q <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (count_q != '1) count_q <= count_q + TW'(1);
                    if (evt_hit) begin
                        ack_q <= 1'b1;
                        state <= S_DONE;
                    end else if (tmo_hit) begin
                        ack_q     <= 1'b1;
                        timeout_q <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
            // A command arriving while one is in flight is refused without disturbing it.
            if (capture && state != S_IDLE) error_q <= 1'b1;
        end
    end

    assign bus.o_ack     = ack_q;
    assign bus.o_timeout = timeout_q;
    assign bus.o_error   = error_q;
    assign bus.o_busy    = busy_q;

`ifdef WAIT_EVENT_MONITOR_LOG_EN
    always_ff @(posedge clk) begin
        if (rst_n && state == S_IDLE && capture)
            $display("[%0t] wait capture cmd=%s alias=%s count=%0d", $time,
                     bus.i_args[0], bus.i_args[1], arg_count);
        if (ack_q)
            $display("[%0t] wait ack cmd=%s alias=%s count=%0d", $time, cmd_str, alias_str, limit_q);
        if (timeout_q)
            $display("[%0t] wait timeout cmd=%s alias=%s count=%0d", $time, cmd_str, alias_str, limit_q);
        if (error_q)
            $display("[%0t] wait error cmd=%s alias=%s count=%0d", $time, cmd_str, alias_str, limit_q);
    end
`else
`endif

endmodule

// File: tb/tb_wait_event_monitor.sv
// tb/tb_wait_event_monitor.sv - scoreboard bench for wait_event_monitor
module tb_wait_event_monitor;

    typedef struct packed {
        logic [31:0] cyc;
        logic        ack;
        logic        tmo;
        logic        err;
    } resp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] wait_sig = '0;
    string      alias_tab [5];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_fail = 0;
    resp_t      sb [$];

    wait_event_monitor_if #(.ARGS_NB(5)) bus ();

    wait_event_monitor #(
        .WAIT_SIZE     (5),
        .ARGS_NB       (5),
        .TIMEOUT_WIDTH (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_wait_alias (alias_tab),
        .i_wait       (wait_sig),
        .bus          (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string fmt(input resp_t r);
        return $sformatf("cyc=%0d ack=%b tmo=%b err=%b", r.cyc, r.ack, r.tmo, r.err);
    endfunction

    task automatic drive_cmd(input string c, input string a, input string n, input logic sel,
                             output int c0);
        @(posedge clk); #1;
        bus.i_sel_wait   = sel;
        bus.i_args_valid = 1'b1;
        bus.i_args[0]    = c;
        bus.i_args[1]    = a;
        bus.i_args[2]    = n;
        c0 = cyc;
        @(posedge clk); #1;
        bus.i_args_valid = 1'b0;
        bus.i_sel_wait   = 1'b0;
    endtask

    task automatic goto_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic get_resp(input int budget, output resp_t o, output logic got);
        o = '0;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (bus.o_ack || bus.o_error) begin
                o = '{cyc: 32'(cyc), ack: bus.o_ack, tmo: bus.o_timeout, err: bus.o_error};
                got = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.o_ack, bus.o_timeout, bus.o_error, bus.o_busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0000",
                     {bus.o_ack, bus.o_timeout, bus.o_error, bus.o_busy});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_rise;
        int c0; resp_t o, e; logic got;
        drive_cmd("WAIT_RISE", "O2", "100", 1'b1, c0);
        goto_cycle(c0 + 10);
        wait_sig[2] = 1'b1;
        sb.push_back('{cyc: 32'(c0 + 11), ack: 1'b1, tmo: 1'b0, err: 1'b0});
        get_resp(40, o, got);
        e = sb.pop_front(); n_cmp++;
        if (!got || o !== e) begin
            n_fail++;
            $display("FAIL rise_ack: got(%0b) %s want %s", got, fmt(o), fmt(e));
        end
        wait_sig[2] = 1'b0;
    endtask

    task automatic test_fall_timeout;
        int c0; resp_t o, e; logic got;
        drive_cmd("WAIT_FALL", "O0", "20", 1'b1, c0);
        sb.push_back('{cyc: 32'(c0 + 22), ack: 1'b1, tmo: 1'b1, err: 1'b0});
        get_resp(60, o, got);
        e = sb.pop_front(); n_cmp++;
        if (!got || o !== e) begin
            n_fail++;
            $display("FAIL fall_timeout: got(%0b) %s want %s", got, fmt(o), fmt(e));
        end
    endtask

    task automatic test_duration;
        int c0; resp_t o, e; logic got; logic busy_bad;
        drive_cmd("WAIT_DURATION", "-", "50", 1'b1, c0);
        sb.push_back('{cyc: 32'(c0 + 52), ack: 1'b1, tmo: 1'b0, err: 1'b0});
        o = '0; got = 1'b0; busy_bad = 1'b0;
        for (int i = 0; i < 90 && !got; i++) begin
            @(negedge clk);
            if (!bus.o_busy) busy_bad = 1'b1;
            if (bus.o_ack || bus.o_error) begin
                o = '{cyc: 32'(cyc), ack: bus.o_ack, tmo: bus.o_timeout, err: bus.o_error};
                got = 1'b1;
            end
        end
        e = sb.pop_front(); n_cmp++;
        if (!got || o !== e) begin
            n_fail++;
            $display("FAIL duration_ack: got(%0b) %s want %s", got, fmt(o), fmt(e));
        end
        n_cmp++;
        if (busy_bad !== 1'b0) begin
            n_fail++;
            $display("FAIL duration_busy: busy dropped=%b want 0", busy_bad);
        end
    endtask

    task automatic test_duration_zero;
        int c0; resp_t o, e; logic got;
        drive_cmd("WAIT_DURATION", "-", "0", 1'b1, c0);
        sb.push_back('{cyc: 32'(c0 + 2), ack: 1'b1, tmo: 1'b0, err: 1'b0});
        get_resp(20, o, got);
        e = sb.pop_front(); n_cmp++;
        if (!got || o !== e) begin
            n_fail++;
            $display("FAIL duration_zero: got(%0b) %s want %s", got, fmt(o), fmt(e));
        end
    endtask

    task automatic test_high_immediate;
        int c0; resp_t o, e; logic got;
        wait_sig[4] = 1'b1;
        drive_cmd("WAIT_HIGH", "O4", "7", 1'b1, c0);
        sb.push_back('{cyc: 32'(c0 + 3), ack: 1'b1, tmo: 1'b0, err: 1'b0});
        get_resp(20, o, got);
        e = sb.pop_front(); n_cmp++;
        if (!got || o !== e) begin
            n_fail++;
            $display("FAIL high_immediate: got(%0b) %s want %s", got, fmt(o), fmt(e));
        end
        wait_sig[4] = 1'b0;
    endtask

    task automatic test_bad_alias;
        int c0; resp_t o, e; logic got;
        drive_cmd("WAIT_HIGH", "X9", "10", 1'b1, c0);
        sb.push_back('{cyc: 32'(c0 + 2), ack: 1'b1, tmo: 1'b0, err: 1'b1});
        get_resp(20, o, got);
        e = sb.pop_front(); n_cmp++;
        if (!got || o !== e) begin
            n_fail++;
            $display("FAIL bad_alias: got(%0b) %s want %s", got, fmt(o), fmt(e));
        end
        @(negedge clk);
        n_cmp++;
        if (bus.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_alias_busy: got %b want 0", bus.o_busy);
        end
    endtask

    task automatic test_bad_command;
        int c0; resp_t o, e; logic got;
        drive_cmd("WAIT_SOON", "O0", "5", 1'b1, c0);
        sb.push_back('{cyc: 32'(c0 + 2), ack: 1'b1, tmo: 1'b0, err: 1'b1});
        get_resp(20, o, got);
        e = sb.pop_front(); n_cmp++;
        if (!got || o !== e) begin
            n_fail++;
            $display("FAIL bad_command: got(%0b) %s want %s", got, fmt(o), fmt(e));
        end
    endtask

    task automatic test_sel_low;
        int c0; int seen;
        drive_cmd("WAIT_DURATION", "-", "0", 1'b0, c0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.o_ack || bus.o_error || bus.o_busy) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL sel_low_ignored: active cycles=%0d want 0", seen);
        end
    endtask

    task automatic test_back_to_back;
        int c0; resp_t o, e; logic got;
        wait_sig[1] = 1'b1;
        drive_cmd("WAIT_LOW", "O1", "0", 1'b1, c0);
        goto_cycle(c0 + 5);
        bus.i_sel_wait   = 1'b1;
        bus.i_args_valid = 1'b1;
        bus.i_args[0]    = "WAIT_DURATION";
        bus.i_args[1]    = "-";
        bus.i_args[2]    = "3";
        goto_cycle(c0 + 6);
        bus.i_sel_wait   = 1'b0;
        bus.i_args_valid = 1'b0;
        sb.push_back('{cyc: 32'(c0 + 6), ack: 1'b0, tmo: 1'b0, err: 1'b1});
        get_resp(20, o, got);
        e = sb.pop_front(); n_cmp++;
        if (!got || o !== e) begin
            n_fail++;
            $display("FAIL busy_reject: got(%0b) %s want %s", got, fmt(o), fmt(e));
        end
        goto_cycle(c0 + 10);
        wait_sig[1] = 1'b0;
        sb.push_back('{cyc: 32'(c0 + 11), ack: 1'b1, tmo: 1'b0, err: 1'b0});
        get_resp(20, o, got);
        e = sb.pop_front(); n_cmp++;
        if (!got || o !== e) begin
            n_fail++;
            $display("FAIL busy_original_ack: got(%0b) %s want %s", got, fmt(o), fmt(e));
        end
    endtask

    task automatic test_reset_abort;
        int c0, c1; int seen; resp_t o, e; logic got;
        drive_cmd("WAIT_RISE", "O3", "0", 1'b1, c0);
        goto_cycle(c0 + 5);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.o_ack, bus.o_timeout, bus.o_error, bus.o_busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL abort_outputs: got %b want 0000",
                     {bus.o_ack, bus.o_timeout, bus.o_error, bus.o_busy});
        end
        goto_cycle(c0 + 8);
        rst_n = 1'b1;
        wait_sig[3] = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.o_ack || bus.o_error || bus.o_busy) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL abort_no_ack: active cycles=%0d want 0", seen);
        end
        wait_sig[3] = 1'b0;
        drive_cmd("WAIT_RISE", "O3", "0", 1'b1, c1);
        goto_cycle(c1 + 4);
        wait_sig[3] = 1'b1;
        sb.push_back('{cyc: 32'(c1 + 5), ack: 1'b1, tmo: 1'b0, err: 1'b0});
        get_resp(20, o, got);
        e = sb.pop_front(); n_cmp++;
        if (!got || o !== e) begin
            n_fail++;
            $display("FAIL after_abort_ack: got(%0b) %s want %s", got, fmt(o), fmt(e));
        end
        wait_sig[3] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 5; k++) alias_tab[k] = $sformatf("O%0d", k);
        bus.i_sel_wait   = 1'b0;
        bus.i_args_valid = 1'b0;
        for (int k = 0; k < 5; k++) bus.i_args[k] = "";
        test_reset();
        test_rise();
        test_fall_timeout();
        test_duration();
        test_duration_zero();
        test_high_immediate();
        test_bad_alias();
        test_bad_command();
        test_sel_low();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
